// File: rtl/fpm_share_arbiter.sv
// Round-robin arbiter that time-multiplexes one signed Q16.16 multiplier
// among NUM_REQ requesters, with a single-entry tagged response buffer.

module fixed_point_multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  logic signed [63:0] full;

  // Full signed product; arithmetic shift keeps bits [47:16] (truncate toward -inf, wrap on overflow).
  assign full = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign p_o  = 32'(full >>> 16);
endmodule

module fpm_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic [15:0]           grant_count
);
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  // Handshake: a beat moves on any channel when valid && ready are both high
  // at a rising edge; ready never depends on the payload of that channel.

  logic [31:0]    a_arr [NUM_REQ];
  logic [31:0]    b_arr [NUM_REQ];
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    grant_count_q, grant_count_d;
  logic           can_accept;
  logic           grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]  cand;
  logic           xfer;
  logic [31:0]    mul_a, mul_b, mul_p;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*32 +: 32];
    assign b_arr[g] = req_b[g*32 +: 32];
  end

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Scan from last_grant+1 upward, wrapping at NUM_REQ; first valid wins.
  always_comb begin
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_accept && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign xfer  = |(req_valid & req_ready);
  assign mul_a = a_arr[grant_idx];
  assign mul_b = b_arr[grant_idx];

  fixed_point_multiplier u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    last_grant_d  = last_grant_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    grant_count_d = grant_count_q;
    if (xfer) begin
      last_grant_d  = grant_idx;
      rsp_valid_d   = 1'b1;
      rsp_data_d    = mul_p;
      rsp_id_d      = grant_idx;
      grant_count_d = grant_count_q + 16'd1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      grant_count_q <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign grant_count = grant_count_q;
endmodule

// File: tb/tb_fpm_share_arbiter.sv
// Directed bench for fpm_share_arbiter: reset, rotation, backpressure,
// arithmetic edges, mid-run reset, request drop and grant-count wrap.

module tb_fpm_share_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ready;
  logic [15:0]  grant_count;

  int checks = 0;
  int errors = 0;

  fpm_share_arbiter #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_ready   (rsp_ready),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    checks++; if (grant_count !== 16'd0) begin errors++; $display("FAIL reset_grant_count got %0d exp 0", grant_count); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_a[31:0] = 32'hFFFE_8000; req_b[31:0] = 32'h0001_0000; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    step();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 32'hFFFE_8000) begin errors++; $display("FAIL single_rsp_data got %h exp fffe8000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id got %0d exp 0", rsp_id); end
    checks++; if (grant_count !== 16'd1) begin errors++; $display("FAIL single_grant_count got %0d exp 1", grant_count); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ready;
    logic [31:0] exp_data;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(i + 1) << 16;
      req_b[i*32 +: 32] = 32'h0002_0000;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_ready = 4'b0001 << (i % 4);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ready, exp_ready); end
      step();
      exp_data = 32'((i % 4 + 1) * 2) << 16;
      checks++; if (rsp_id !== 2'(i % 4)) begin errors++; $display("FAIL rr_rsp_id[%0d] got %0d exp %0d", i, rsp_id, i % 4); end
      checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL rr_rsp_data[%0d] got %h exp %h", i, rsp_data, exp_data); end
    end
    checks++; if (grant_count !== 16'd8) begin errors++; $display("FAIL rr_grant_count got %0d exp 8", grant_count); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0110; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready got %b exp 0010", req_ready); end
    step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d exp v=1 id=1", i, rsp_valid, rsp_id); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", req_ready); end
    step();
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL bp_release_id got %0d exp 2", rsp_id); end
    checks++; if (grant_count !== 16'd2) begin errors++; $display("FAIL bp_grant_count got %0d exp 2", grant_count); end
    req_valid = '0;
  endtask

  task automatic test_arith();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vp [4];
    va[0] = 32'h0002_0000; vb[0] = 32'hFFFE_8000; vp[0] = 32'hFFFD_0000;
    va[1] = 32'h0000_0001; vb[1] = 32'h0000_0001; vp[1] = 32'h0000_0000;
    va[2] = 32'h7FFF_0000; vb[2] = 32'h0002_0000; vp[2] = 32'hFFFE_0000;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0001; vp[3] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0001; req_a[31:0] = va[i]; req_b[31:0] = vb[i];
      step();
      req_valid = '0;
      checks++; if (rsp_data !== vp[i]) begin errors++; $display("FAIL arith[%0d] got %h exp %h", i, rsp_data, vp[i]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_valid = 4'b1100; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mr_first_ready got %b exp 0100", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL mr_loaded got v=%b id=%0d exp v=1 id=2", rsp_valid, rsp_id); end
    rst = 1'b1; rsp_ready = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (grant_count !== 16'd0) begin errors++; $display("FAIL mr_grant_count got %0d exp 0", grant_count); end
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mr_after_ready got %b exp 0100", req_ready); end
    step();
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL mr_after_id got %0d exp 2", rsp_id); end
    req_valid = '0;
  endtask

  task automatic test_drop();
    do_reset();
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drop_before got %b exp 0010", req_ready); end
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL drop_after got %b exp 1000", req_ready); end
    step();
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL drop_rsp_id got %0d exp 3", rsp_id); end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    checks++; if (grant_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", grant_count); end
    step();
    checks++; if (grant_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", grant_count); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_arith();
    test_mid_reset();
    test_drop();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
